// File: rtl/adc_pkg.sv
// Shared types for the ADC packetizer: FSM states, beat layout
// and width helpers.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int CHANNELS_DEF = 1;
  localparam int BEAT_W_DEF   = DATA_W_DEF * CHANNELS_DEF;

  // Reference layout of a stored beat at the default widths.
  typedef struct packed {
    logic                  tlast;
    logic [BEAT_W_DEF-1:0] data;
  } beat_t;

  function automatic int beat_w(int dw, int ch);
    return dw * ch;
  endfunction

endpackage

// File: rtl/adc_packetizer_if.sv
// AXI4-Stream beat bundle between the packetizer and the
// S2MM DMA.
interface adc_packetizer_if #(
  parameter int BEAT_W = 16
);
  logic [BEAT_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with
// full/empty/count status.
module sync_fifo #(
  parameter  int W     = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push;
  logic         do_pop;

  // Full is judged on current occupancy, so a pop never frees
  // room for a push in the same cycle.
  assign count_o = wptr_q - rptr_q;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign empty_o = wptr_q == rptr_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/adc_packetizer.sv
// Multi-channel ADC sample packetizer: capture FSM, test pattern,
// overflow tracking and AXIS packet output through a FWFT FIFO.
module adc_packetizer
  import adc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CHANNELS   = CHANNELS_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int SIZE_W     = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         adc_valid,
  input  logic [DATA_W*CHANNELS-1:0]   adc_data,
  input  logic                         cfg_start,
  input  logic                         cfg_stop,
  input  logic                         cfg_continuous,
  input  logic                         cfg_test_pattern,
  input  logic [SIZE_W-1:0]            cfg_packet_beats,
  input  logic                         ovf_clr,
  adc_packetizer_if.master             m_axis,
  output logic                         busy,
  output logic                         overflow,
  output logic [31:0]                  packet_count
);

  localparam int BEAT_W = beat_w(DATA_W, CHANNELS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic              tlast;
    logic [BEAT_W-1:0] data;
  } fbeat_t;

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] len_q, len_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              cont_q, cont_d;
  logic              stop_q, stop_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       pkt_q, pkt_d;

  fbeat_t            wbeat, rbeat;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              cap, wr, drop, last, pop;
  logic [BEAT_W-1:0] pat_beat;

  always_comb begin
    pat_beat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pat_beat[k*DATA_W +: DATA_W] = pat_q + DATA_W'(k);
    end
  end

  assign cap         = state_q == CAPTURE;
  assign wr          = cap & adc_valid & ~fifo_full;
  assign drop        = cap & adc_valid & fifo_full;
  assign last        = cnt_q == len_q - SIZE_W'(1);
  assign wbeat.tlast = last;
  assign wbeat.data  = cfg_test_pattern ? pat_beat : adc_data;
  assign pop         = ~fifo_empty & m_axis.tready;

  sync_fifo #(
    .W     (BEAT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr),
    .wdata_i (wbeat),
    .pop_i   (pop),
    .rdata_o (rbeat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Gate the head so stale RAM never shows while empty.
  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : rbeat.data;
  assign m_axis.tlast  = ~fifo_empty & rbeat.tlast;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    stop_d  = stop_q;
    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (cfg_start && cfg_packet_beats != '0) begin
          state_d = CAPTURE;
          len_d   = cfg_packet_beats;
          cont_d  = cfg_continuous;
          cnt_d   = '0;
          pat_d   = '0;
        end
      end
      CAPTURE: begin
        stop_d = stop_q | cfg_stop;
        if (wr) begin
          pat_d = pat_q + DATA_W'(1);
          cnt_d = last ? '0 : cnt_q + SIZE_W'(1);
          if (last && !(cont_q && !stop_d)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_cnt == '0) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_d = drop | (ovf_q & ~ovf_clr);
  assign pkt_d = pkt_q + 32'(pop & m_axis.tlast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
      pkt_q   <= pkt_d;
    end
  end

  assign busy         = state_q != IDLE;
  assign overflow     = ovf_q;
  assign packet_count = pkt_q;

endmodule

// File: tb/tb_adc_packetizer.sv
// Bench for adc_packetizer: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_adc_packetizer;
  import adc_pkg::*;

  localparam int DW    = 16;
  localparam int CH    = 4;
  localparam int DEPTH = 16;
  localparam int SW    = 24;
  localparam int BW    = DW * CH;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
  } mb_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          adc_valid = 1'b0;
  logic [BW-1:0] adc_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cont = 1'b0;
  logic          tp = 1'b0;
  logic [SW-1:0] plen = '0;
  logic          ovf_clr = 1'b0;
  logic          busy, overflow;
  logic [31:0]   packet_count;

  int n_chk = 0;
  int n_err = 0;

  adc_packetizer_if #(.BEAT_W(BW)) axis ();

  adc_packetizer #(
    .DATA_W     (DW),
    .CHANNELS   (CH),
    .FIFO_DEPTH (DEPTH),
    .SIZE_W     (SW)
  ) dut (
    .clk              (clk),
    .reset            (rst),
    .adc_valid        (adc_valid),
    .adc_data         (adc_data),
    .cfg_start        (start),
    .cfg_stop         (stop),
    .cfg_continuous   (cont),
    .cfg_test_pattern (tp),
    .cfg_packet_beats (plen),
    .ovf_clr          (ovf_clr),
    .m_axis           (axis),
    .busy             (busy),
    .overflow         (overflow),
    .packet_count     (packet_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pattern(int p);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[k*DW +: DW] = DW'(p + k);
    return r;
  endfunction

  // Behavioural model: what the capture should have accepted and
  // what is still waiting to leave, as a queue of beats.
  bit   m_cap = 0, m_drain = 0, m_cont = 0, m_stop = 0, m_ovf = 0;
  int   m_len = 0, m_cnt = 0, m_pat = 0;
  logic [31:0] m_pkts = '0;
  mb_t  m_q[$];
  mb_t  seen[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cap = 0; m_drain = 0; m_cont = 0; m_stop = 0; m_ovf = 0;
      m_len = 0; m_cnt = 0; m_pat = 0; m_pkts = '0;
      m_q.delete();
    end else begin : mdl
      bit  do_pop, full, was_empty, dropped, pushed;
      mb_t b;
      do_pop    = (m_q.size() != 0) && axis.tready;
      full      = m_q.size() == DEPTH;
      was_empty = m_q.size() == 0;
      dropped   = 0;
      pushed    = 0;
      b.d       = '0;
      b.l       = 0;
      if (m_cap) begin
        if (stop) m_stop = 1;
        if (adc_valid) begin
          if (full) begin
            m_ovf   = 1;
            dropped = 1;
          end else begin
            b.d    = tp ? pattern(m_pat) : adc_data;
            b.l    = (m_cnt == m_len - 1);
            pushed = 1;
            m_pat  = (m_pat + 1) % 65536;
            m_cnt++;
            if (b.l) begin
              m_cnt = 0;
              if (!m_cont || m_stop) begin
                m_cap   = 0;
                m_drain = 1;
              end
            end
          end
        end
      end else if (m_drain) begin
        if (was_empty) begin
          m_drain = 0;
          m_stop  = 0;
        end
      end else if (start && plen != '0) begin
        m_cap  = 1;
        m_len  = int'(plen);
        m_cont = cont;
        m_cnt  = 0;
        m_pat  = 0;
        m_stop = 0;
      end
      if (ovf_clr && !dropped) m_ovf = 0;
      if (do_pop) begin
        if (m_q[0].l) m_pkts = m_pkts + 32'd1;
        void'(m_q.pop_front());
      end
      if (pushed) m_q.push_back(b);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("tvalid", 64'(axis.tvalid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("tdata", 64'(axis.tdata), 64'(m_q[0].d));
        check("tlast", 64'(axis.tlast), 64'(m_q[0].l));
      end
      check("busy", 64'(busy), 64'(m_cap || m_drain));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("pkt_cnt", 64'(packet_count), 64'(m_pkts));
      if (axis.tvalid && axis.tready) seen.push_back('{d: axis.tdata, l: axis.tlast});
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pkt(int len, bit c, bit t);
    plen  = SW'(len);
    cont  = c;
    tp    = t;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int i;
    i = 0;
    while ((busy || axis.tvalid) && i < max) begin
      step();
      i++;
    end
    check("idle_timeout", 64'(busy || axis.tvalid), 64'(0));
  endtask

  task automatic check_seq(string tag, int n, int last_every);
    check({tag, "_len"}, 64'(seen.size()), 64'(n));
    for (int i = 0; i < seen.size() && i < n; i++) begin
      check({tag, "_data"}, 64'(seen[i].d), 64'(pattern(i)));
      check({tag, "_last"}, 64'(seen[i].l), 64'((i % last_every) == last_every - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    axis.tready = 1'b0;
    step(3);
    check("rst_tvalid", 64'(axis.tvalid), 64'(0));
    check("rst_tdata", 64'(axis.tdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_pkts", 64'(packet_count), 64'(0));
    rst = 1'b0;
    step(2);

    // Single-shot, length 8, pattern
    axis.tready = 1'b1;
    seen.delete();
    base = packet_count;
    adc_valid = 1'b1;
    start_pkt(8, 0, 1);
    check("busy_rise", 64'(busy), 64'(1));
    step(12);
    adc_valid = 1'b0;
    wait_idle(50);
    check_seq("single", 8, 8);
    check("single_pkts", 64'(packet_count), 64'(base + 32'd1));

    // Continuous, length 4, stop during packet 3
    seen.delete();
    base = packet_count;
    adc_valid = 1'b1;
    start_pkt(4, 1, 1);
    step(10);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(8);
    adc_valid = 1'b0;
    wait_idle(50);
    check_seq("cont", 12, 4);
    if (seen.size() >= 5) begin
      check("cont_p1b0", 64'(seen[0].d), 64'h0003_0002_0001_0000);
      check("cont_p2b0", 64'(seen[4].d), 64'h0007_0006_0005_0004);
    end
    check("cont_pkts", 64'(packet_count), 64'(base + 32'd3));

    // Backpressure: 16 buffered, 24 dropped
    seen.delete();
    axis.tready = 1'b0;
    adc_valid = 1'b1;
    start_pkt(64, 0, 1);
    step(40);
    check("bp_ovf", 64'(overflow), 64'(1));
    check("bp_none_out", 64'(seen.size()), 64'(0));
    axis.tready = 1'b1;
    step(80);
    adc_valid = 1'b0;
    wait_idle(100);
    check_seq("bp", 64, 64);

    // Overflow clear behaviour
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr_alone", 64'(overflow), 64'(0));
    axis.tready = 1'b0;
    adc_valid = 1'b1;
    start_pkt(64, 0, 1);
    step(20);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr_drop", 64'(overflow), 64'(1));
    adc_valid = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr_after", 64'(overflow), 64'(0));
    axis.tready = 1'b1;
    adc_valid = 1'b1;
    step(80);
    adc_valid = 1'b0;
    wait_idle(100);

    // Zero length ignored; start while busy ignored
    seen.delete();
    base = packet_count;
    adc_valid = 1'b1;
    start_pkt(0, 0, 1);
    step(3);
    check("len0_busy", 64'(busy), 64'(0));
    check("len0_out", 64'(seen.size()), 64'(0));
    adc_valid = 1'b0;
    start_pkt(6, 0, 1);
    step(2);
    start_pkt(2, 1, 1);
    adc_valid = 1'b1;
    step(12);
    adc_valid = 1'b0;
    wait_idle(50);
    check_seq("restart", 6, 6);
    check("restart_pkts", 64'(packet_count), 64'(base + 32'd1));

    // Reset mid-packet
    axis.tready = 1'b0;
    adc_valid = 1'b1;
    start_pkt(10, 0, 1);
    step(5);
    adc_valid = 1'b0;
    check("pre_rst_tvalid", 64'(axis.tvalid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(axis.tvalid), 64'(0));
    check("mid_rst_tdata", 64'(axis.tdata), 64'(0));
    check("mid_rst_tlast", 64'(axis.tlast), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ovf", 64'(overflow), 64'(0));
    check("mid_rst_pkts", 64'(packet_count), 64'(0));
    step(2);
    rst = 1'b0;
    axis.tready = 1'b1;
    seen.delete();
    adc_valid = 1'b1;
    start_pkt(3, 0, 1);
    step(6);
    adc_valid = 1'b0;
    wait_idle(50);
    check_seq("post_rst", 3, 3);

    // Random traffic against the model
    for (int r = 0; r < 6; r++) begin
      adc_valid = 1'b0;
      start_pkt($urandom_range(12, 1), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)));
      for (int c = 0; c < 150; c++) begin
        adc_valid   = $urandom_range(99, 0) < 70;
        adc_data    = {$urandom(), $urandom()};
        axis.tready = $urandom_range(99, 0) < 60;
        stop        = $urandom_range(99, 0) < 2;
        ovf_clr     = $urandom_range(99, 0) < 5;
        start       = $urandom_range(99, 0) < 3;
        plen        = SW'($urandom_range(12, 0));
        tp          = 1'($urandom_range(1, 0));
        step();
      end
      start = 1'b0;
      ovf_clr = 1'b0;
      stop = 1'b1;
      adc_valid = 1'b1;
      axis.tready = 1'b1;
      for (int c = 0; c < 200 && busy; c++) step();
      stop = 1'b0;
      adc_valid = 1'b0;
      wait_idle(100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adc_packetizer.md
# adc_packetizer

Parametrised multi-channel ADC sample packetizer. It is the successor of the single-channel fixed-size capture path in `digitizer`. It takes one sample set per `adc_valid` from the ADC front end, optionally substitutes an incrementing test pattern, and emits fixed-length AXI4-Stream packets with TLAST to the S2MM DMA. It supports single-shot and continuous capture, backpressure buffering, overflow detection and packet counting.

## Interface
Parameters:
- `DATA_W`, 16, bits per channel sample (8..16)
- `CHANNELS`, 1, channels per beat (1..4); beat width `BEAT_W = DATA_W*CHANNELS`
- `FIFO_DEPTH`, 16, buffer depth in beats, power of two, ≥ 4
- `SIZE_W`, 24, width of packet length field

Ports:
- `clk` in 1: ADC-domain clock
- `reset` in 1: asynchronous, active-high
- `adc_valid` in 1: sample set present this cycle
- `adc_data` in BEAT_W: channel k occupies bits [k*DATA_W +: DATA_W]
- `cfg_start` in 1: one-cycle pulse, begin capture
- `cfg_stop` in 1: one-cycle pulse, stop at next packet boundary
- `cfg_continuous` in 1: 1 = back-to-back packets until stop
- `cfg_test_pattern` in 1: 1 = replace `adc_data` with counter pattern
- `cfg_packet_beats` in SIZE_W: beats per packet
- `ovf_clr` in 1: clears `overflow`
- `m_axis_tdata` out BEAT_W
- `m_axis_tvalid` out 1
- `m_axis_tready` in 1
- `m_axis_tlast` out 1
- `busy` out 1: state ≠ IDLE
- `overflow` out 1: sticky, a sample was dropped
- `packet_count` out 32: completed output packets, wraps

## Operation
- FSM states:
  - IDLE:
    - `cfg_start` with `cfg_packet_beats ≠ 0` → CAPTURE.
    - On entry to CAPTURE: latch `cfg_packet_beats` and `cfg_continuous`, zero the beat counter and the pattern counter.
    - `cfg_start` with length 0 is ignored.
  - CAPTURE:
    - Each `adc_valid` with FIFO not full writes one beat; the beat counter increments.
    - The beat written when `count == len-1` carries TLAST.
    - After the TLAST write:
      - if latched continuous and no stop is pending, the counter is zeroed and CAPTURE continues;
      - otherwise → DRAIN.
  - DRAIN: FIFO empty → IDLE.
- `cfg_stop` in CAPTURE sets `stop_pending`; it takes effect only at the next TLAST write. Packets are never truncated. `stop_pending` clears on entering IDLE.
- `cfg_start` outside IDLE is ignored.
- Overflow:
  - `adc_valid` in CAPTURE while the FIFO is full → sample dropped and `overflow` ← 1.
  - The beat counter and pattern counter do not advance.
  - `ovf_clr` clears `overflow`; a simultaneous drop wins (stays 1).
- Test pattern: channel k = (pattern_cnt + k) mod 2^DATA_W. `pattern_cnt` increments per written beat and wraps at 2^DATA_W.
- `packet_count` increments on the output handshake with `tlast` (tvalid & tready & tlast) and wraps from 2^32-1 to 0.
- `adc_valid` outside CAPTURE is discarded and does not set overflow.

## Timing
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0.
- `busy` rises the cycle after the `cfg_start` edge.
- Latency: a beat written at clock edge N is presented on `m_axis_tvalid`/`tdata` after edge N (visible in cycle N+1) if the FIFO was empty.
- AXIS handshake:
  - `tdata`/`tlast` stay stable while `tvalid & ~tready`.
  - `tvalid` is never withdrawn without a handshake.
- Full is evaluated on the current occupancy. A push while full is dropped even if a pop occurs in the same cycle. Simultaneous push and pop at non-full occupancy keeps occupancy unchanged.
- Full throughput: one beat per cycle sustained with `tready` = 1.
- `busy` falls the cycle after the last FIFO beat is handshaken in DRAIN.
- Reset asserted mid-packet: immediate return to reset values; a partial packet is lost and no TLAST is emitted.

## Structure
- Package `adc_pkg`:
  - `state_t` enum {IDLE, CAPTURE, DRAIN};
  - `beat_t` struct {tlast, data};
  - width localparams derived from DATA_W/CHANNELS.
- Sub-module `sync_fifo` (parametrised width/depth, first-word-fall-through, full/empty/count). It stores `{tlast, data}`.
- The FSM, counters, pattern generator and overflow logic live in `adc_packetizer`.

## Test plan
- Single-shot, CHANNELS=1, test pattern, length 8, tready=1, `adc_valid` every cycle → exactly 8 beats 0..7, TLAST on beat 7, `packet_count`=1, `busy` low afterward.
- Continuous, CHANNELS=4, DATA_W=16, length 4, stop pulsed during packet 3 → 3 packets total. Beat 0 of packet 1 = {3,2,1,0}; pattern is continuous across packets (packet 2 beat 0 = {7,6,5,4}); no truncation.
- Backpressure: FIFO_DEPTH=16, length 64, tready=0 for 40 cycles → 16 beats buffered, 24 drops, `overflow`=1. Output beats are in order, and TLAST falls on the 64th beat actually written.
- `ovf_clr` together with a drop → `overflow` stays 1. `ovf_clr` alone → 0 next cycle.
- Length 0 with start → `busy` stays 0 and no output. A start pulse while busy → ignored and packet length unchanged.
- Reset asserted mid-packet after 5 of 10 beats → all outputs 0 immediately. A following start with length 3 produces pattern 0,1,2 with TLAST on 2.
